// File: rtl/mem_lsu_pkg.sv
// Shared LSU definitions: aluop codes, bus widths, reset constants and
// lane/size helpers used by mem_lsu and mem_load_align.
package mem_lsu_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int SEL_W      = 4;
  localparam int REG_ADDR_W = 5;

  localparam logic [DATA_W-1:0]     ZERO_WORD    = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [ALU_OP_W-1:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {SZ_NONE = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2, SZ_WORD = 2'd3} acc_size_t;

  function automatic acc_size_t op_size(input logic [ALU_OP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:          op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:          op_size = SZ_HALF;
      EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP: op_size = SZ_WORD;
      default:                                   op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP: is_load_op = 1'b1;
      default: is_load_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [ALU_OP_W-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_store_op = 1'b1;
      default: is_store_op = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [ALU_OP_W-1:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Byte lanes are big-endian: address offset 0 is bus_sel[3].
  function automatic logic [SEL_W-1:0] lane_sel(input logic [ALU_OP_W-1:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_BYTE: begin
        case (lo)
          2'b00:   lane_sel = 4'b1000;
          2'b01:   lane_sel = 4'b0100;
          2'b10:   lane_sel = 4'b0010;
          default: lane_sel = 4'b0001;
        endcase
      end
      SZ_HALF: lane_sel = lo[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [ALU_OP_W-1:0] op, input logic [DATA_W-1:0] reg2);
    case (op_size(op))
      SZ_BYTE: store_data = {4{reg2[7:0]}};
      SZ_HALF: store_data = {2{reg2[15:0]}};
      default: store_data = reg2;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select and sign/zero extension of a captured
// big-endian bus word.
module mem_load_align
  import mem_lsu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W-1:0]   result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data[7:0];
    half_v = addr_lo[1] ? data[15:0] : data[31:16];
    case (addr_lo)
      2'b00:   byte_v = data[31:24];
      2'b01:   byte_v = data[23:16];
      2'b10:   byte_v = data[15:8];
      default: byte_v = data[7:0];
    endcase
    case (aluop)
      EXE_LB_OP:  result = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: result = {24'h000000, byte_v};
      EXE_LH_OP:  result = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: result = {16'h0000, half_v};
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE bus handshake with stall request.
// Optional LL/SC link bit enabled by defining LLSC_EN.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [ADDR_W-1:0]     mem_mem_addr,
  input  logic [ALU_OP_W-1:0]   mem_aluop,
  input  logic [DATA_W-1:0]     mem_reg2,
  input  logic                  flush,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [SEL_W-1:0]      bus_sel,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  stallreq,
  output logic                  excep_adel,
  output logic                  excep_ades
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] load_data;
  logic              is_load, is_store, is_mem, misal, sc_fail, start;

  assign is_load  = is_load_op(mem_aluop);
  assign is_store = is_store_op(mem_aluop);
  assign is_mem   = is_load | is_store;
  assign misal    = misaligned(mem_aluop, mem_mem_addr[1:0]);

`ifdef LLSC_EN
  logic llbit;
  assign sc_fail = (mem_aluop == EXE_SC_OP) && !llbit;

  // Link bit: set by a completed LL, cleared by SC, flush or reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      llbit <= 1'b0;
    end else if (state == DONE && mem_aluop == EXE_LL_OP) begin
      llbit <= 1'b1;
    end else if (mem_aluop == EXE_SC_OP && !misal && state != BUSY) begin
      llbit <= 1'b0;
    end else begin
      llbit <= llbit;
    end
  end
`else
  assign sc_fail = 1'b0;
`endif

  assign start = is_mem && !misal && !sc_fail;

  mem_load_align u_align (
    .aluop   (mem_aluop),
    .addr_lo (mem_mem_addr[1:0]),
    .data    (data_q),
    .result  (load_data)
  );

  // Handshake state and captured read data; flush abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= ZERO_WORD;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: state <= start ? BUSY : IDLE;
        BUSY: begin
          if (bus_ack) begin
            data_q <= bus_rdata;
            state  <= DONE;
          end else begin
            state <= BUSY;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus, stall, exception and writeback outputs; reset and flush quiet them all.
  always_comb begin
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = ZERO_WORD;
    bus_sel    = 4'b0000;
    bus_wdata  = ZERO_WORD;
    stallreq   = 1'b0;
    excep_adel = 1'b0;
    excep_ades = 1'b0;
    wb_wdata   = ZERO_WORD;
    wb_wd      = NOP_REG_ADDR;
    wb_wreg    = 1'b0;
    if (rst || flush) begin
      wb_wreg = 1'b0;
    end else begin
      wb_wd = mem_wd;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_wdata = mem_wdata;
            wb_wreg  = mem_wreg;
          end else if (misal) begin
            excep_adel = is_load;
            excep_ades = is_store;
          end else if (sc_fail) begin
            wb_wreg = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        BUSY: begin
          stallreq  = 1'b1;
          bus_req   = 1'b1;
          bus_we    = is_store;
          bus_addr  = {mem_mem_addr[31:2], 2'b00};
          bus_sel   = lane_sel(mem_aluop, mem_mem_addr[1:0]);
          bus_wdata = is_store ? store_data(mem_aluop, mem_reg2) : ZERO_WORD;
        end
        DONE: begin
          if (is_load) begin
            wb_wdata = load_data;
            wb_wreg  = 1'b1;
          end else if (mem_aluop == EXE_SC_OP) begin
            wb_wdata = 32'd1;
            wb_wreg  = 1'b1;
          end else begin
            wb_wreg = 1'b0;
          end
        end
        default: wb_wreg = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences for
// flush/reset/ack corner cases, and randomized ops against a byte-level model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic        clk, rst, flush, mem_wreg, wb_wreg, bus_req, bus_we, bus_ack;
  logic        stallreq, excep_adel, excep_ades;
  logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, wb_wdata, bus_addr, bus_wdata, bus_rdata;
  logic [4:0]  mem_wd, wb_wd;
  logic [7:0]  mem_aluop;
  logic [3:0]  bus_sel;

  int checks = 0;
  int failures = 0;
  bit llb = 1'b0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .mem_reg2(mem_reg2), .flush(flush),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .stallreq(stallreq), .excep_adel(excep_adel), .excep_ades(excep_ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        access;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] wb_wdata;
    logic        wb_wreg;
    logic        adel;
    logic        ades;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        wreg;
    int          delay;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic acc, input logic we, input logic [3:0] sel,
                              input logic [31:0] bw, input logic [31:0] wb, input logic wreg,
                              input logic adel, input logic ades);
    ex = '{acc, we, sel, bw, wb, wreg, adel, ades};
  endfunction

  // Reference: access size, alignment, byte lanes and extension from address arithmetic.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic [31:0] rdata, input logic [31:0] wdata, input logic wreg,
                                 input bit link);
    exp_t e;
    int size, off;
    bit ld, st, sgn;
    logic [31:0] v, m;
    e = '0; size = 0; ld = 0; st = 0; sgn = 0;
    case (op)
      EXE_LB_OP:             begin size = 1; ld = 1; sgn = 1; end
      EXE_LBU_OP:            begin size = 1; ld = 1; end
      EXE_LH_OP:             begin size = 2; ld = 1; sgn = 1; end
      EXE_LHU_OP:            begin size = 2; ld = 1; end
      EXE_LW_OP, EXE_LL_OP:  begin size = 4; ld = 1; end
      EXE_SB_OP:             begin size = 1; st = 1; end
      EXE_SH_OP:             begin size = 2; st = 1; end
      EXE_SW_OP, EXE_SC_OP:  begin size = 4; st = 1; end
      default:               size = 0;
    endcase
    if (size == 0) begin
      e.wb_wdata = wdata; e.wb_wreg = wreg;
      return e;
    end
    off = int'(addr % 32'd4);
    if (off % size != 0) begin
      e.adel = ld; e.ades = st;
      return e;
    end
    if (op == EXE_SC_OP && LLSC && !link) begin
      e.wb_wreg = 1'b1;
      return e;
    end
    e.access = 1'b1; e.we = st;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + size) e.sel[3-i] = 1'b1;
    if (st) for (int j = 0; j < 4; j++) e.bwdata[31-8*j -: 8] = 8'(reg2 >> (8 * (size - 1 - (j % size))));
    if (ld) begin
      v = rdata >> (8 * (4 - off - size));
      if (size < 4) begin
        m = (32'd1 << (8 * size)) - 32'd1;
        v = v & m;
        if (sgn && v[8*size-1]) v = v | ~m;
      end
      e.wb_wdata = v; e.wb_wreg = 1'b1;
    end
    if (op == EXE_SC_OP) begin e.wb_wdata = 32'd1; e.wb_wreg = 1'b1; end
    return e;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
  endtask

  // One instruction through the stage; ack is raised in the delay-th bus cycle.
  task automatic do_txn(input string tag, input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input logic [31:0] wdata, input logic [4:0] wd,
                        input logic wreg, input int delay, input exp_t e);
    int stalls;
    drive(op, addr, reg2, wdata, wd, wreg);
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = ~rdata;
    stalls = 0;
    @(negedge clk);
    chk({tag, ".adel"}, excep_adel, e.adel);
    chk({tag, ".ades"}, excep_ades, e.ades);
    chk({tag, ".req_idle"}, bus_req, 1'b0);
    if (!e.access) begin
      chk({tag, ".stall"}, stallreq, 1'b0);
      chk({tag, ".wreg"}, wb_wreg, e.wb_wreg);
      chk({tag, ".wdata"}, wb_wdata, e.wb_wdata);
      chk({tag, ".wd"}, wb_wd, wd);
      @(posedge clk); #1;
      return;
    end
    stalls += int'(stallreq);
    for (int k = 1; k <= delay; k++) begin
      @(posedge clk); #1;
      if (k == delay) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk);
      stalls += int'(stallreq);
      chk({tag, ".req"}, bus_req, 1'b1);
      chk({tag, ".we"}, bus_we, e.we);
      chk({tag, ".sel"}, bus_sel, e.sel);
      chk({tag, ".addr"}, bus_addr, addr & 32'hFFFF_FFFC);
      chk({tag, ".bwdata"}, bus_wdata, e.bwdata);
      chk({tag, ".wreg_busy"}, wb_wreg, 1'b0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk({tag, ".stall_done"}, stallreq, 1'b0);
    chk({tag, ".req_done"}, bus_req, 1'b0);
    chk({tag, ".wreg"}, wb_wreg, e.wb_wreg);
    chk({tag, ".wdata"}, wb_wdata, e.wb_wdata);
    chk({tag, ".wd"}, wb_wd, wd);
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(delay + 1));
    @(posedge clk); #1;
  endtask

  // Non-memory op used to prove the FSM sits in IDLE.
  task automatic expect_idle(input string tag, input logic [31:0] wdata);
    drive(EXE_OR_OP, 32'h0, 32'h0, wdata, 5'd7, 1'b1);
    @(negedge clk);
    chk({tag, ".idle_stall"}, stallreq, 1'b0);
    chk({tag, ".idle_req"}, bus_req, 1'b0);
    chk({tag, ".idle_wreg"}, wb_wreg, 1'b1);
    chk({tag, ".idle_wdata"}, wb_wdata, wdata);
    @(posedge clk); #1;
  endtask

  vec_t vt[13];
  logic [7:0] ops[12];

  initial begin
    rst = 1'b1; flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    drive(EXE_LW_OP, 32'h100, 32'h1234_5678, 32'h9999_9999, 5'd3, 1'b1);

    // Reset state, with a live memory op and ack on the inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.bus_req", bus_req, 1'b0);     chk("rst.bus_we", bus_we, 1'b0);
    chk("rst.bus_sel", bus_sel, 4'b0000);  chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.bus_wdata", bus_wdata, 32'h0); chk("rst.stallreq", stallreq, 1'b0);
    chk("rst.adel", excep_adel, 1'b0);     chk("rst.ades", excep_ades, 1'b0);
    chk("rst.wb_wdata", wb_wdata, 32'h0);  chk("rst.wb_wd", wb_wd, 5'd0);
    chk("rst.wb_wreg", wb_wreg, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b0;

    vt[0]  = '{EXE_LW_OP,  32'h100, 32'h0,         32'hDEADBEEF, 32'h0, 1'b0, 3, ex(1,0,4'b1111,32'h0,32'hDEADBEEF,1,0,0)};
    vt[1]  = '{EXE_LB_OP,  32'h103, 32'h0,         32'h123456F0, 32'h0, 1'b0, 1, ex(1,0,4'b0001,32'h0,32'hFFFFFFF0,1,0,0)};
    vt[2]  = '{EXE_LBU_OP, 32'h103, 32'h0,         32'h123456F0, 32'h0, 1'b0, 2, ex(1,0,4'b0001,32'h0,32'h000000F0,1,0,0)};
    vt[3]  = '{EXE_SH_OP,  32'h202, 32'h0000ABCD,  32'h0,        32'h0, 1'b0, 1, ex(1,1,4'b0011,32'hABCDABCD,32'h0,0,0,0)};
    vt[4]  = '{EXE_LW_OP,  32'h101, 32'h0,         32'h0,        32'h0, 1'b0, 1, ex(0,0,4'b0000,32'h0,32'h0,0,1,0)};
    vt[5]  = '{EXE_SW_OP,  32'h102, 32'h11111111,  32'h0,        32'h0, 1'b0, 1, ex(0,0,4'b0000,32'h0,32'h0,0,0,1)};
    vt[6]  = '{EXE_LH_OP,  32'h100, 32'h0,         32'h80011234, 32'h0, 1'b0, 1, ex(1,0,4'b1100,32'h0,32'hFFFF8001,1,0,0)};
    vt[7]  = '{EXE_LHU_OP, 32'h102, 32'h0,         32'h8001F234, 32'h0, 1'b0, 4, ex(1,0,4'b0011,32'h0,32'h0000F234,1,0,0)};
    vt[8]  = '{EXE_SB_OP,  32'h101, 32'h000000A5,  32'h0,        32'h0, 1'b0, 1, ex(1,1,4'b0100,32'hA5A5A5A5,32'h0,0,0,0)};
    vt[9]  = '{EXE_SW_OP,  32'h104, 32'hCAFEF00D,  32'h0,        32'h0, 1'b0, 2, ex(1,1,4'b1111,32'hCAFEF00D,32'h0,0,0,0)};
    vt[10] = '{EXE_LH_OP,  32'h101, 32'h0,         32'h0,        32'h0, 1'b0, 1, ex(0,0,4'b0000,32'h0,32'h0,0,1,0)};
    vt[11] = '{EXE_OR_OP,  32'h0,   32'h0,         32'h0,        32'h11223344, 1'b1, 1, ex(0,0,4'b0000,32'h0,32'h11223344,1,0,0)};
    vt[12] = '{EXE_SH_OP,  32'h203, 32'h0000ABCD,  32'h0,        32'h0, 1'b0, 1, ex(0,0,4'b0000,32'h0,32'h0,0,0,1)};

    for (int i = 0; i < 13; i++)
      do_txn($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].reg2, vt[i].rdata,
             vt[i].wdata, 5'(i + 1), vt[i].wreg, vt[i].delay, vt[i].e);

    // Flush in BUSY with ack in the same cycle: no writeback, back to IDLE.
    if (LLSC) begin
      do_txn("ll_pre", EXE_LL_OP, 32'h300, 32'h0, 32'h0000_0042, 32'h0, 5'd9, 1'b1, 1,
             ex(1,0,4'b1111,32'h0,32'h0000_0042,1,0,0));
      llb = 1'b1;
    end
    drive(EXE_LW_OP, 32'h100, 32'h0, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    chk("flush.idle_stall", stallreq, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("flush.req", bus_req, 1'b0);
    chk("flush.wreg", wb_wreg, 1'b0);
    chk("flush.stall", stallreq, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; bus_ack = 1'b0; llb = 1'b0;
    expect_idle("flush", 32'h0BADF00D);
    if (LLSC)
      do_txn("flush.sc", EXE_SC_OP, 32'h300, 32'h77, 32'h0, 32'h0, 5'd9, 1'b1, 1,
             ex(0,0,4'b0000,32'h0,32'h0,1,0,0));

    // bus_ack while IDLE must not move the FSM.
    drive(EXE_OR_OP, 32'h0, 32'h0, 32'h0000_1111, 5'd7, 1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("idleack.stall", stallreq, 1'b0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    expect_idle("idleack", 32'h0000_2222);

    // Reset in the middle of BUSY abandons the access.
    drive(EXE_SW_OP, 32'h400, 32'hAAAA_5555, 32'h0, 5'd5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy.req", bus_req, 1'b0);
    chk("rstbusy.stall", stallreq, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; llb = 1'b0;
    expect_idle("rstbusy", 32'h0000_3333);

    // LL then SC succeeds; a second SC fails without touching the bus.
    do_txn("ll", EXE_LL_OP, 32'h300, 32'h0, 32'hFEED_0001, 32'h0, 5'd10, 1'b1, 2,
           model(EXE_LL_OP, 32'h300, 32'h0, 32'hFEED_0001, 32'h0, 1'b1, llb));
    if (LLSC) llb = 1'b1;
    do_txn("sc1", EXE_SC_OP, 32'h300, 32'h1357_9BDF, 32'h0, 32'h0, 5'd10, 1'b1, 1,
           ex(1,1,4'b1111,32'h1357_9BDF,32'h1,1,0,0));
    llb = 1'b0;
    do_txn("sc2", EXE_SC_OP, 32'h300, 32'h2468_ACE0, 32'h0, 32'h0, 5'd10, 1'b1, 1,
           model(EXE_SC_OP, 32'h300, 32'h2468_ACE0, 32'h0, 32'h0, 1'b1, llb));

    // Randomized instructions against the model.
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP, EXE_OR_OP, EXE_NOP_OP};
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  op;
      logic [31:0] addr, reg2, rdata, wdata;
      logic [4:0]  wd;
      logic        wreg;
      int          dly;
      exp_t        e;
      op = ops[$urandom_range(11, 0)];
      addr = $urandom;
      if ($urandom_range(1, 0) == 0) addr[1:0] = 2'b00;
      reg2 = $urandom; rdata = $urandom; wdata = $urandom;
      wd = 5'($urandom); wreg = 1'($urandom); dly = $urandom_range(4, 1);
      e = model(op, addr, reg2, rdata, wdata, wreg, llb);
      do_txn($sformatf("rnd%0d", n), op, addr, reg2, rdata, wdata, wd, wreg, dly, e);
      if (LLSC && op == EXE_LL_OP && e.access) llb = 1'b1;
      else if (op == EXE_SC_OP && !e.ades) llb = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
